// File: rtl/sha1_digest_wb.sv
// -----------------------------------------------------------------------------
// sha1_digest_wb
//   Write-back stage behind the SHA-1 engine. When the engine pulses
//   digest_valid_i, the block latches the 160-bit digest and a word-aligned
//   destination address. It then writes the digest to data memory as five
//   32-bit words over a single-master req/gnt bus, most significant word first.
//   After the fifth grant it pulses done_o. If one word waits TIMEOUT cycles
//   without a grant, it pulses err_o and abandons the transfer. A digest that
//   arrives while the block is busy is dropped and reported on overrun_o.
//
// Parameters
//   ADDR_STRIDE  byte increment between consecutive digest words
//   TIMEOUT      max cycles one word may wait for a grant (>= 1)
//
// Ports
//   clk             in   1    system clock, rising edge
//   rst             in   1    asynchronous reset, active low
//   digest_i        in   160  SHA-1 result, word0 = [159:128] ... word4 = [31:0]
//   digest_addr_i   in   32   destination byte address of word0
//   digest_valid_i  in   1    one-cycle capture strobe from the engine
//   busy_o          out  1    capture held, write-back in progress
//   done_o          out  1    one-cycle pulse, all five words granted
//   err_o           out  1    one-cycle pulse, grant timeout, transfer aborted
//   overrun_o       out  1    one-cycle pulse, a digest was dropped while busy
//   mem_req_o       out  1    bus request
//   mem_we_o        out  1    write enable, always equal to mem_req_o
//   mem_addr_o      out  32   word byte address, bits [1:0] always 0
//   mem_data_o      out  32   write data
//   mem_gnt_i       in   1    grant; a word completes on an edge with req & gnt
// -----------------------------------------------------------------------------
module sha1_digest_wb #(
    parameter int unsigned ADDR_STRIDE = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [159:0] digest_i,
    input  logic [31:0]  digest_addr_i,
    input  logic         digest_valid_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         overrun_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [31:0]  mem_addr_o,
    output logic [31:0]  mem_data_o,
    input  logic         mem_gnt_i
);

    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       IDX_LAST = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q;
    logic [159:0]     digest_q;
    logic [31:0]      base_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             overrun_q;

    logic [31:0]      word_sel;
    logic [31:0]      addr_sum;

    // NOTE: state is updated only with non-blocking assignments so that every
    // register samples the values present before the edge, whatever the order
    // of statements in this block.
    // NOTE: the digest register is reset together with the control state.
    // Although it is wide, it is a flop bank rather than a memory. Clearing it
    // keeps the bus outputs at a known value after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            digest_q  <= '0;
            base_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // A strobe is accepted only in IDLE. In any other state, including
            // the DONE/ERR cycle, it is dropped and flagged here.
            overrun_q <= digest_valid_i && (state_q != S_IDLE);

            case (state_q)
                S_IDLE: begin
                    if (digest_valid_i) begin
                        digest_q <= digest_i;
                        base_q   <= digest_addr_i & 32'hFFFF_FFFC;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (mem_gnt_i) begin
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            // The request stays high, so the next word follows
                            // back-to-back.
                            idx_q <= idx_q + 3'd1;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        // This is the TIMEOUT-th ungranted cycle on this word.
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DONE:  state_q <= S_IDLE;
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: every signal driven from always_comb gets a default first. The
    // default keeps an unlisted index from inferring a latch.
    always_comb begin
        word_sel = '0;
        case (idx_q)
            3'd0:    word_sel = digest_q[159:128];
            3'd1:    word_sel = digest_q[127:96];
            3'd2:    word_sel = digest_q[95:64];
            3'd3:    word_sel = digest_q[63:32];
            3'd4:    word_sel = digest_q[31:0];
            default: word_sel = '0;
        endcase
    end

    // The address wraps modulo 2^32 without any indication.
    assign addr_sum = base_q + (32'(idx_q) * ADDR_STRIDE);

    // Outputs are decoded from registers only, so mem_gnt_i has no
    // combinational path to any output.
    assign mem_req_o  = (state_q == S_WRITE);
    assign mem_we_o   = mem_req_o;
    assign mem_addr_o = mem_req_o ? (addr_sum & 32'hFFFF_FFFC) : '0;
    assign mem_data_o = mem_req_o ? word_sel : '0;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = (state_q == S_ERR);
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_sha1_digest_wb.sv
// -----------------------------------------------------------------------------
// tb_sha1_digest_wb
//   Directed bench for sha1_digest_wb with TIMEOUT=8. It covers reset, a
//   zero-wait write-back, a stalled word, an overrun, a grant timeout and the
//   boundary just below it, address wrap-around, and reset in mid-transfer.
//   Expected words and addresses are written out by hand.
// -----------------------------------------------------------------------------
module tb_sha1_digest_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic [159:0] digest_i;
    logic [31:0]  digest_addr_i;
    logic         digest_valid_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic         overrun_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_data_o;
    logic         mem_gnt_i;

    int checks   = 0;
    int failures = 0;

    // Accepted writes and pulse counts, sampled mid-cycle on the falling edge.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int ovr_cnt  = 0;

    // SHA-1("1234") and SHA-1("abc").
    localparam logic [159:0] DIG1 = 160'h7110eda4_d09e062a_a5e4a390_b0a572ac_0d2c0220;
    localparam logic [159:0] DIG2 = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    logic [31:0] w1 [5] = '{32'h7110eda4, 32'hd09e062a, 32'ha5e4a390, 32'hb0a572ac, 32'h0d2c0220};
    logic [31:0] w2 [5] = '{32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d};
    logic [31:0] a1 [5] = '{32'h10001000, 32'h10001004, 32'h10001008, 32'h1000100C, 32'h10001010};
    logic [31:0] a5 [5] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004, 32'h00000008};
    logic [31:0] a6 [5] = '{32'h40000000, 32'h40000004, 32'h40000008, 32'h4000000C, 32'h40000010};

    int d0;
    int e0;
    int o0;

    sha1_digest_wb #(
        .ADDR_STRIDE(4),
        .TIMEOUT    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .digest_i      (digest_i),
        .digest_addr_i (digest_addr_i),
        .digest_valid_i(digest_valid_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .overrun_o     (overrun_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_gnt_i     (mem_gnt_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req_o && mem_gnt_i) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_data_o);
        end
        if (done_o)    done_cnt++;
        if (err_o)     err_cnt++;
        if (overrun_o) ovr_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] base, input logic [159:0] dig);
        digest_i       = dig;
        digest_addr_i  = base;
        digest_valid_i = 1'b1;
        tick();
        digest_valid_i = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rst            = 1'b0;
        digest_i       = '0;
        digest_addr_i  = '0;
        digest_valid_i = 1'b0;
        mem_gnt_i      = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",  mem_req_o,  1'b0);
        check("rst_we",   mem_we_o,   1'b0);
        check("rst_busy", busy_o,     1'b0);
        check("rst_done", done_o,     1'b0);
        check("rst_err",  err_o,      1'b0);
        check("rst_ovr",  overrun_o,  1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        rst = 1'b1;
        tick();

        // ---------------- test 1: zero wait states ----------------
        mem_gnt_i = 1'b1;   // also held during IDLE, where it must be ignored
        clear_log();
        d0 = done_cnt;
        tick();
        check("t1_idle_gnt_ignored", busy_o, 1'b0);
        launch(32'h10001000, DIG1);
        for (int i = 0; i < 5; i++) begin
            check("t1_req",  mem_req_o,  1'b1);
            check("t1_we",   mem_we_o,   1'b1);
            check("t1_busy", busy_o,     1'b1);
            check("t1_addr", mem_addr_o, a1[i]);
            check("t1_data", mem_data_o, w1[i]);
            tick();
        end
        check("t1_done",      done_o,    1'b1);
        check("t1_done_req",  mem_req_o, 1'b0);
        check("t1_done_busy", busy_o,    1'b1);
        tick();
        check("t1_done_fall", done_o, 1'b0);
        check("t1_idle_busy", busy_o, 1'b0);
        check("t1_done_cnt",  done_cnt - d0, 1);
        check("t1_wr_cnt",    wr_addr.size(), 5);

        // ---------------- test 2: word 2 stalled 3 cycles ----------------
        clear_log();
        d0 = done_cnt;
        e0 = err_cnt;
        launch(32'h10001000, DIG1);
        for (int i = 0; i < 5; i++) begin
            check("t2_addr", mem_addr_o, a1[i]);
            check("t2_data", mem_data_o, w1[i]);
            if (i == 2) begin
                mem_gnt_i = 1'b0;
                repeat (3) begin
                    tick();
                    check("t2_hold_req",  mem_req_o,  1'b1);
                    check("t2_hold_addr", mem_addr_o, 32'h10001008);
                    check("t2_hold_data", mem_data_o, 32'ha5e4a390);
                end
                mem_gnt_i = 1'b1;
            end
            tick();
        end
        check("t2_done", done_o, 1'b1);
        tick();
        check("t2_err_cnt",  err_cnt - e0, 0);
        check("t2_done_cnt", done_cnt - d0, 1);
        check("t2_wr_cnt",   wr_addr.size(), 5);

        // ---------------- test 3: overrun during WRITE and in the DONE cycle ----------------
        clear_log();
        o0 = ovr_cnt;
        launch(32'h10001000, DIG1);
        tick();                         // word0 granted, now on word1
        digest_i       = DIG2;
        digest_addr_i  = 32'h20000000;
        digest_valid_i = 1'b1;
        tick();                         // strobe dropped, now on word2
        digest_valid_i = 1'b0;
        check("t3_ovr",       overrun_o,  1'b1);
        check("t3_ovr_addr",  mem_addr_o, 32'h10001008);
        check("t3_ovr_data",  mem_data_o, 32'ha5e4a390);
        tick();                         // word3
        check("t3_ovr_fall",  overrun_o,  1'b0);
        tick();                         // word4
        tick();                         // DONE
        check("t3_done", done_o, 1'b1);
        digest_valid_i = 1'b1;          // strobe in the DONE cycle
        tick();
        digest_valid_i = 1'b0;
        check("t3_done_ovr",  overrun_o, 1'b1);
        check("t3_done_busy", busy_o,    1'b0);
        tick();
        check("t3_no_capture", mem_req_o, 1'b0);
        check("t3_ovr_cnt",    ovr_cnt - o0, 2);
        check("t3_wr_cnt",     wr_addr.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_addr.size()) begin
                check("t3_img_addr", wr_addr[i], a1[i]);
                check("t3_img_data", wr_data[i], w1[i]);
            end
        end

        // ---------------- test 4: grant timeout ----------------
        clear_log();
        d0 = done_cnt;
        e0 = err_cnt;
        mem_gnt_i = 1'b0;
        launch(32'h30000000, DIG1);
        for (int i = 0; i < 8; i++) begin
            check("t4_req",  mem_req_o,  1'b1);
            check("t4_addr", mem_addr_o, 32'h30000000);
            tick();
        end
        check("t4_err",      err_o,     1'b1);
        check("t4_err_req",  mem_req_o, 1'b0);
        check("t4_err_done", done_o,    1'b0);
        tick();
        check("t4_err_fall", err_o,  1'b0);
        check("t4_idle",     busy_o, 1'b0);
        check("t4_err_cnt",  err_cnt - e0,  1);
        check("t4_done_cnt", done_cnt - d0, 0);
        check("t4_wr_cnt",   wr_addr.size(), 0);

        // ---------------- test 4b: grant on the last allowed cycle ----------------
        clear_log();
        d0 = done_cnt;
        e0 = err_cnt;
        launch(32'h30000000, DIG1);
        repeat (7) tick();              // eighth waiting cycle on word0
        check("t4b_still_req", mem_req_o, 1'b1);
        mem_gnt_i = 1'b1;
        repeat (5) tick();
        check("t4b_done",    done_o, 1'b1);
        tick();
        check("t4b_err_cnt", err_cnt - e0,  0);
        check("t4b_done_cnt", done_cnt - d0, 1);
        check("t4b_wr_cnt",  wr_addr.size(), 5);

        // ---------------- test 5: address wrap, unaligned base ----------------
        launch(32'hFFFFFFFA, DIG1);
        for (int i = 0; i < 5; i++) begin
            check("t5_addr", mem_addr_o, a5[i]);
            check("t5_data", mem_data_o, w1[i]);
            tick();
        end
        check("t5_done", done_o, 1'b1);
        tick();

        // ---------------- test 6: reset while word 3 is pending ----------------
        d0 = done_cnt;
        e0 = err_cnt;
        launch(32'h10001000, DIG1);
        repeat (3) tick();              // words 0..2 granted
        mem_gnt_i = 1'b0;
        tick();
        check("t6_pend_addr", mem_addr_o, 32'h1000100C);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_req",  mem_req_o,  1'b0);
        check("t6_rst_we",   mem_we_o,   1'b0);
        check("t6_rst_busy", busy_o,     1'b0);
        check("t6_rst_done", done_o,     1'b0);
        check("t6_rst_err",  err_o,      1'b0);
        check("t6_rst_addr", mem_addr_o, 32'h0);
        check("t6_rst_data", mem_data_o, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("t6_post_idle", busy_o, 1'b0);
        mem_gnt_i = 1'b1;
        launch(32'h40000000, DIG2);
        for (int i = 0; i < 5; i++) begin
            check("t6_addr", mem_addr_o, a6[i]);
            check("t6_data", mem_data_o, w2[i]);
            tick();
        end
        check("t6_done", done_o, 1'b1);
        tick();
        check("t6_done_cnt", done_cnt - d0, 1);
        check("t6_err_cnt",  err_cnt - e0,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
